traffic_signal_monitor: RTL and testbench

Independent lamp-side checker for the 4-way intersection controller. It samples the 16 lamp drives (A/B/C/D × red/yellow/green_ls/green) and decodes them back into the controller phase. It verifies that every pattern is legal, every transition follows the fixed A→C→B→D sequence and every phase dwell is exact. Any violation latches a sticky fault for the safety/conflict-monitor path.

---
 rtl/traffic_pkg.sv | 101 ++++++++++
 rtl/traffic_lamp_decoder.sv | 36 +++
 rtl/traffic_signal_monitor.sv | 165 ++++++++++++++++
 tb/tb_traffic_signal_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection lamp monitor.
//   phase_e        : controller phase encoding (4 bits, 10 legal codes)
//   LAMP_*         : bit positions inside a 4-bit approach lamp nibble
//   fault_code_e   : violation codes reported by the monitor
//   mon_state_e    : monitor FSM states
//   next_phase     : fixed A -> C -> B -> D successor order
//   expected_dwell : cycles a phase is held (threshold + 1)
//   lamp_pattern   : 16-bit {A,B,C,D} lamp vector for each legal phase
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [3:0] {
        PH_A_C_GREEN_LS = 4'd0,
        PH_A_GREEN      = 4'd1,
        PH_A_YELLOW     = 4'd2,
        PH_B_D_GREEN_LS = 4'd3,
        PH_B_GREEN      = 4'd4,
        PH_B_YELLOW     = 4'd5,
        PH_C_GREEN      = 4'd6,
        PH_C_YELLOW     = 4'd7,
        PH_D_GREEN      = 4'd8,
        PH_D_YELLOW     = 4'd9
    } phase_e;

    localparam int unsigned NUM_PHASES = 10;

    // Lamp nibble bit order is {green, green_ls, yellow, red}.
    localparam int unsigned LAMP_RED      = 0;
    localparam int unsigned LAMP_YELLOW   = 1;
    localparam int unsigned LAMP_GREEN_LS = 2;
    localparam int unsigned LAMP_GREEN    = 3;

    localparam logic [3:0] LAMP_R = 4'(1 << LAMP_RED);
    localparam logic [3:0] LAMP_Y = 4'(1 << LAMP_YELLOW);
    localparam logic [3:0] LAMP_L = 4'(1 << LAMP_GREEN_LS);
    localparam logic [3:0] LAMP_G = 4'(1 << LAMP_GREEN);

    typedef enum logic [2:0] {
        FC_NONE               = 3'd0,
        FC_ILLEGAL_PATTERN    = 3'd1,
        FC_ILLEGAL_TRANSITION = 3'd2,
        FC_DWELL_SHORT        = 3'd3,
        FC_DWELL_LONG         = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FAULT  = 2'd2
    } mon_state_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_A_GREEN:      return PH_A_C_GREEN_LS;
            PH_A_C_GREEN_LS: return PH_A_YELLOW;
            PH_A_YELLOW:     return PH_C_GREEN;
            PH_C_GREEN:      return PH_C_YELLOW;
            PH_C_YELLOW:     return PH_B_GREEN;
            PH_B_GREEN:      return PH_B_D_GREEN_LS;
            PH_B_D_GREEN_LS: return PH_B_YELLOW;
            PH_B_YELLOW:     return PH_D_GREEN;
            PH_D_GREEN:      return PH_D_YELLOW;
            default:         return PH_A_GREEN;
        endcase
    endfunction

    function automatic logic [7:0] expected_dwell(
        input phase_e      p,
        input int unsigned green_all,
        input int unsigned green_ls,
        input int unsigned yellow
    );
        int unsigned t;
        case (p)
            PH_A_GREEN, PH_B_GREEN,
            PH_C_GREEN, PH_D_GREEN:           t = green_all;
            PH_A_C_GREEN_LS, PH_B_D_GREEN_LS: t = green_ls;
            default:                          t = yellow;
        endcase
        return 8'(t + 1);
    endfunction

    // Returns {lamp_a, lamp_b, lamp_c, lamp_d}.
    function automatic logic [15:0] lamp_pattern(input phase_e p);
        case (p)
            PH_A_C_GREEN_LS: return {LAMP_L, LAMP_R, LAMP_L, LAMP_R};
            PH_A_GREEN:      return {LAMP_G, LAMP_R, LAMP_R, LAMP_R};
            PH_A_YELLOW:     return {LAMP_Y, LAMP_R, LAMP_L, LAMP_R};
            PH_B_D_GREEN_LS: return {LAMP_R, LAMP_L, LAMP_R, LAMP_L};
            PH_B_GREEN:      return {LAMP_R, LAMP_G, LAMP_R, LAMP_R};
            PH_B_YELLOW:     return {LAMP_R, LAMP_Y, LAMP_R, LAMP_L};
            PH_C_GREEN:      return {LAMP_R, LAMP_R, LAMP_G, LAMP_R};
            PH_C_YELLOW:     return {LAMP_R, LAMP_R, LAMP_Y, LAMP_R};
            PH_D_GREEN:      return {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
            default:         return {LAMP_R, LAMP_R, LAMP_R, LAMP_Y};
        endcase
    endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// -----------------------------------------------------------------------------
// traffic_lamp_decoder
// Combinational map from the 16 lamp drives to the controller phase.
//   i_lamp_a..d : approach lamp nibbles {green, green_ls, yellow, red}
//   o_phase     : decoded phase code (0 when not legal)
//   o_legal     : vector exactly matches one of the 10 legal patterns
// -----------------------------------------------------------------------------
module traffic_lamp_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] i_lamp_a,
    input  logic [3:0] i_lamp_b,
    input  logic [3:0] i_lamp_c,
    input  logic [3:0] i_lamp_d,
    output logic [3:0] o_phase,
    output logic       o_legal
);

    logic [15:0] w_lamps;

    assign w_lamps = {i_lamp_a, i_lamp_b, i_lamp_c, i_lamp_d};

    // Exact whole-vector match: dark approaches, multiple lamps on one
    // approach and conflicting greens all fall through as illegal.
    always_comb begin
        o_phase = '0;
        o_legal = 1'b0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (w_lamps == lamp_pattern(phase_e'(i[3:0]))) begin
                o_phase = i[3:0];
                o_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_signal_monitor.sv
// -----------------------------------------------------------------------------
// traffic_signal_monitor
// Lamp-side checker for the 4-way intersection controller. Samples the lamp
// drives, decodes the phase and checks pattern legality, sequence order and
// exact phase dwell. The first violation latches a sticky fault.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ctrl_rst        : controller reset, resynchronises without a fault
//   lamp_a..lamp_d  : lamp drives {green, green_ls, yellow, red}
//   fault_clr       : clears a latched fault (FAULT state only)
//   phase           : decoded phase code
//   phase_valid     : tracking a legal phase
//   fault           : sticky violation flag
//   fault_code      : first violation code
//   cycle_count     : completed D_YELLOW -> A_GREEN signal cycles
// -----------------------------------------------------------------------------
module traffic_signal_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TIME_ALL = 5,
    parameter int unsigned GREEN_TIME_LS  = 10,
    parameter int unsigned YELLOW_TIME    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_rst,
    input  logic [3:0]  lamp_a,
    input  logic [3:0]  lamp_b,
    input  logic [3:0]  lamp_c,
    input  logic [3:0]  lamp_d,
    input  logic        fault_clr,
    output logic [3:0]  phase,
    output logic        phase_valid,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [15:0] cycle_count
);

    logic [15:0] r_sample;
    logic        r_armed;
    mon_state_e  r_state;
    phase_e      r_phase;
    logic        r_phase_valid;
    logic        r_fault;
    fault_code_e r_fault_code;
    logic [15:0] r_cycle_count;
    logic [7:0]  r_dwell;
    logic        r_first;

    logic [3:0]  w_dec_raw;
    logic        w_legal;
    phase_e      w_dec_phase;
    logic [7:0]  w_expected;
    logic        w_changed;
    logic        w_is_succ;
    fault_code_e w_viol;

    traffic_lamp_decoder u_decoder (
        .i_lamp_a (r_sample[15:12]),
        .i_lamp_b (r_sample[11:8]),
        .i_lamp_c (r_sample[7:4]),
        .i_lamp_d (r_sample[3:0]),
        .o_phase  (w_dec_raw),
        .o_legal  (w_legal)
    );

    assign w_dec_phase = phase_e'(w_dec_raw);
    assign w_expected  = expected_dwell(r_phase, GREEN_TIME_ALL, GREEN_TIME_LS, YELLOW_TIME);
    assign w_changed   = (w_dec_phase != r_phase);
    assign w_is_succ   = (w_dec_phase == next_phase(r_phase));

    // Violation priority while tracking; dwell checks are skipped for the
    // first phase after sync because its start was never observed.
    always_comb begin
        w_viol = FC_NONE;
        if (!w_legal) begin
            w_viol = FC_ILLEGAL_PATTERN;
        end else if (w_changed && !w_is_succ) begin
            w_viol = FC_ILLEGAL_TRANSITION;
        end else if (w_changed && !r_first && (r_dwell < w_expected)) begin
            w_viol = FC_DWELL_SHORT;
        end else if (!w_changed && !r_first && (r_dwell >= w_expected)) begin
            w_viol = FC_DWELL_LONG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample      <= '0;
            r_armed       <= 1'b0;
            r_state       <= ST_UNSYNC;
            r_phase       <= PH_A_C_GREEN_LS;
            r_phase_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FC_NONE;
            r_cycle_count <= '0;
            r_dwell       <= '0;
            r_first       <= 1'b0;
        end else begin
            r_sample <= {lamp_a, lamp_b, lamp_c, lamp_d};
            // The sample register still holds its reset zeros on the first
            // edge after reset release; that one evaluation is skipped.
            r_armed  <= 1'b1;

            case (r_state)
                ST_UNSYNC: begin
                    r_phase_valid <= 1'b0;
                    if (!ctrl_rst && r_armed) begin
                        if (w_legal) begin
                            r_state       <= ST_TRACK;
                            r_phase       <= w_dec_phase;
                            r_phase_valid <= 1'b1;
                            r_dwell       <= 8'd1;
                            r_first       <= 1'b1;
                        end else begin
                            r_state      <= ST_FAULT;
                            r_fault      <= 1'b1;
                            r_fault_code <= FC_ILLEGAL_PATTERN;
                        end
                    end
                end

                ST_TRACK: begin
                    if (ctrl_rst) begin
                        r_state       <= ST_UNSYNC;
                        r_phase_valid <= 1'b0;
                    end else if (w_viol != FC_NONE) begin
                        r_state       <= ST_FAULT;
                        r_phase_valid <= 1'b0;
                        r_fault       <= 1'b1;
                        r_fault_code  <= w_viol;
                    end else if (w_changed) begin
                        if (r_phase == PH_D_YELLOW) begin
                            r_cycle_count <= r_cycle_count + 16'd1;
                        end
                        r_phase <= w_dec_phase;
                        r_dwell <= 8'd1;
                        r_first <= 1'b0;
                    end else if (r_dwell != 8'hFF) begin
                        r_dwell <= r_dwell + 8'd1;
                    end
                end

                ST_FAULT: begin
                    if (fault_clr) begin
                        r_state      <= ST_UNSYNC;
                        r_fault      <= 1'b0;
                        r_fault_code <= FC_NONE;
                    end
                end

                default: begin
                    r_state       <= ST_UNSYNC;
                    r_phase_valid <= 1'b0;
                end
            endcase
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_signal_monitor
// Drives the monitor from a behavioural controller or directed lamp patterns.
// Each driven cycle a bench-side reference model pushes the expected outputs;
// they are popped and compared just after the following clock edge.
// -----------------------------------------------------------------------------
module tb_traffic_signal_monitor;

    localparam int GA = 5;
    localparam int GL = 10;
    localparam int YT = 2;

    localparam logic [3:0] R = 4'b0001;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] G = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic        ctrl_rst;
    logic        fault_clr;
    logic [3:0]  lamp_a, lamp_b, lamp_c, lamp_d;
    logic [3:0]  phase;
    logic        phase_valid;
    logic        fault;
    logic [2:0]  fault_code;
    logic [15:0] cycle_count;

    typedef struct packed {
        logic        valid;
        logic        flt;
        logic [2:0]  code;
        logic [3:0]  ph;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    traffic_signal_monitor #(
        .GREEN_TIME_ALL (GA),
        .GREEN_TIME_LS  (GL),
        .YELLOW_TIME    (YT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_rst    (ctrl_rst),
        .lamp_a      (lamp_a),
        .lamp_b      (lamp_b),
        .lamp_c      (lamp_c),
        .lamp_d      (lamp_d),
        .fault_clr   (fault_clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference tables ----------------
    function automatic logic [15:0] pat_of(input int c);
        case (c)
            0: return {L, R, L, R};
            1: return {G, R, R, R};
            2: return {Y, R, L, R};
            3: return {R, L, R, L};
            4: return {R, G, R, R};
            5: return {R, Y, R, L};
            6: return {R, R, G, R};
            7: return {R, R, Y, R};
            8: return {R, R, R, G};
            default: return {R, R, R, Y};
        endcase
    endfunction

    function automatic int seq_at(input int i);
        case (i)
            0: return 1;  1: return 0;  2: return 2;  3: return 6;  4: return 7;
            5: return 4;  6: return 3;  7: return 5;  8: return 8;  default: return 9;
        endcase
    endfunction

    function automatic int dw_of(input int c);
        if (c == 1 || c == 4 || c == 6 || c == 8) return GA + 1;
        if (c == 0 || c == 3) return GL + 1;
        return YT + 1;
    endfunction

    function automatic int pos_of(input int c);
        for (int i = 0; i < 10; i++) if (seq_at(i) == c) return i;
        return 0;
    endfunction

    // ---------------- reference model ----------------
    int          m_state;   // 0 unsync, 1 track, 2 fault
    logic [3:0]  m_phase;
    logic        m_valid, m_fault, m_first, m_armed;
    logic [2:0]  m_code;
    logic [15:0] m_cnt;
    int          m_dwell;
    logic [15:0] m_prev;

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_valid = 0; m_fault = 0; m_first = 0;
        m_armed = 0; m_code = 0; m_cnt = 0; m_dwell = 0; m_prev = 0;
    endtask

    task automatic model_fault(input int code);
        m_state = 2; m_fault = 1; m_code = 3'(code); m_valid = 0;
    endtask

    task automatic model_step(input logic [15:0] lamps, input logic crst, input logic fclr);
        int   c;
        logic legal;
        c = 0;
        legal = 0;
        for (int i = 0; i < 10; i++) if (pat_of(i) == m_prev) begin c = i; legal = 1; end
        if (m_state == 0) begin
            if (!crst && m_armed) begin
                if (legal) begin
                    m_state = 1; m_phase = 4'(c); m_dwell = 1; m_first = 1; m_valid = 1;
                end else model_fault(1);
            end
        end else if (m_state == 1) begin
            if (crst) begin
                m_state = 0; m_valid = 0;
            end else if (!legal) model_fault(1);
            else if (c != int'(m_phase)) begin
                if (seq_at((pos_of(int'(m_phase)) + 1) % 10) != c) model_fault(2);
                else if (!m_first && m_dwell < dw_of(int'(m_phase))) model_fault(3);
                else begin
                    if (m_phase == 4'd9) m_cnt = m_cnt + 16'd1;
                    m_phase = 4'(c); m_dwell = 1; m_first = 0;
                end
            end else if (!m_first && m_dwell >= dw_of(int'(m_phase))) model_fault(4);
            else if (m_dwell < 255) m_dwell++;
        end else if (fclr) begin
            m_state = 0; m_fault = 0; m_code = 0;
        end
        m_armed = 1;
        m_prev  = lamps;
    endtask

    // ---------------- stimulus ----------------
    // Entered and left at a falling edge.
    task automatic drive(input logic [15:0] lamps, input logic crst, input logic fclr);
        exp_t e;
        {lamp_a, lamp_b, lamp_c, lamp_d} = lamps;
        ctrl_rst  = crst;
        fault_clr = fclr;
        model_step(lamps, crst, fclr);
        e = '{valid: m_valid, flt: m_fault, code: m_code, ph: m_phase, cnt: m_cnt};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_valid", phase_valid, e.valid);
        check("sb_fault", fault, e.flt);
        check("sb_code", fault_code, e.code);
        check("sb_phase", phase, e.ph);
        check("sb_count", cycle_count, e.cnt);
        @(negedge clk);
    endtask

    int ctl_idx, ctl_tmr;

    task automatic ctl_cycle(input logic crst, input logic fclr);
        drive(pat_of(seq_at(ctl_idx)), crst, fclr);
        if (crst) begin
            ctl_idx = 0; ctl_tmr = 0;
        end else if (ctl_tmr == dw_of(seq_at(ctl_idx)) - 1) begin
            ctl_idx = (ctl_idx + 1) % 10; ctl_tmr = 0;
        end else ctl_tmr++;
    endtask

    task automatic hold(input int code, input int n);
        for (int i = 0; i < n; i++) drive(pat_of(code), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ctrl_rst = 1'b0; fault_clr = 1'b0;
        {lamp_a, lamp_b, lamp_c, lamp_d} = '0;
        #1;
        check("rst_phase", phase, 0);
        check("rst_valid", phase_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_count", cycle_count, 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        sb_q.delete();
        ctl_idx = 0; ctl_tmr = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ctrl_rst = 1'b0; fault_clr = 1'b0;
        {lamp_a, lamp_b, lamp_c, lamp_d} = '0;
        @(negedge clk);

        // Normal controller operation over three full cycles.
        do_reset();
        for (int i = 0; i < 3 * 58 + 10; i++) ctl_cycle(1'b0, 1'b0);
        check("run_fault", fault, 0);
        check("run_count", cycle_count, 3);
        check("run_valid", phase_valid, 1);

        // Conflicting green during B_GREEN.
        for (int i = 0; i < 100 && seq_at(ctl_idx) != 4; i++) ctl_cycle(1'b0, 1'b0);
        ctl_cycle(1'b0, 1'b0);
        ctl_cycle(1'b0, 1'b0);
        drive({G, G, R, R}, 1'b0, 1'b0);
        drive({G, G, R, R}, 1'b0, 1'b0);
        check("ill_fault", fault, 1);
        check("ill_code", fault_code, 1);
        check("ill_valid", phase_valid, 0);
        check("ill_phase_hold", phase, 4);

        // Clear, resync mid-phase, then fully checked operation.
        ctl_cycle(1'b0, 1'b1);
        check("clr_fault", fault, 0);
        check("clr_code", fault_code, 0);
        check("clr_valid", phase_valid, 0);
        for (int i = 0; i < 70; i++) ctl_cycle(1'b0, 1'b0);
        check("resync_fault", fault, 0);
        check("resync_valid", phase_valid, 1);

        // Out-of-order transition.
        do_reset();
        hold(1, 6);
        hold(6, 2);
        check("trans_fault", fault, 1);
        check("trans_code", fault_code, 2);

        // Short dwell.
        do_reset();
        hold(1, 6);
        hold(0, 8);
        hold(2, 2);
        check("short_code", fault_code, 3);

        // Long dwell: 11 samples fine, the 12th faults.
        do_reset();
        hold(1, 6);
        hold(0, 12);
        check("long_edge_ok", fault, 0);
        hold(0, 1);
        check("long_fault", fault, 1);
        check("long_code", fault_code, 4);

        // Controller reset mid B_D_GREEN_LS.
        do_reset();
        for (int i = 0; i < 62; i++) ctl_cycle(1'b0, 1'b0);
        for (int i = 0; i < 100 && seq_at(ctl_idx) != 3; i++) ctl_cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ctl_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ctl_cycle(1'b1, 1'b0);
        check("crst_unsync", phase_valid, 0);
        for (int i = 0; i < 3; i++) ctl_cycle(1'b0, 1'b0);
        check("crst_fault", fault, 0);
        check("crst_count", cycle_count, 1);
        check("crst_valid", phase_valid, 1);
        check("crst_phase", phase, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
